// File: rtl/barker_pkg.sv
// Shared Barker-13 definitions, common to the spreader and the correlator.
//   BARKER_LEN       : chips per Barker word
//   BARKER13         : chip pattern, chip 0 at bit index 0 (1 = +1, 0 = -1)
//   spreader_state_t : spreader FSM states
package barker_pkg;

    localparam int unsigned BARKER_LEN = 13;

    // Chip order 1111100110101 with chip 0 first, so the literal reads reversed.
    localparam logic [BARKER_LEN-1:0] BARKER13 = 13'b1010110011111;

    typedef enum logic [1:0] {
        StIdle,
        StPreamble,
        StLoad,
        StData
    } spreader_state_t;

endpackage

// File: rtl/barker_spreader_if.sv
// 1-bit AXI-Stream bundle.
//   master : drives tdata/tvalid/tlast/tuser, receives tready
//   slave  : receives tdata/tvalid/tlast, drives tready (tuser is unused on input)
interface barker_spreader_if;

    logic tdata;
    logic tvalid;
    logic tready;
    logic tlast;
    logic tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/barker_chip_rom.sv
// Combinational chip lookup: maps (chip index, symbol bit) to one output chip.
//   chip_idx : chip position 0..12 within the word
//   sym_bit  : symbol bit; 1 emits the code, 0 emits its inverse
//   chip     : resulting chip (1 = +1, 0 = -1)
module barker_chip_rom
    import barker_pkg::*;
(
    input  logic [3:0] chip_idx,
    input  logic       sym_bit,
    output logic       chip
);

    always_comb begin
        chip = 1'b0;
        if (chip_idx <= 4'd12) begin
            chip = BARKER13[chip_idx] ~^ sym_bit;
        end
    end

endmodule

// File: rtl/barker_spreader.sv
// Spreads each payload bit into one 13-chip Barker word, with an optional
// per-frame preamble of PREAMBLE_SYMBOLS all-ones words.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   s_axis  : payload bit stream in (tdata, tvalid, tlast, tready)
//   m_axis  : chip stream out (tdata, tvalid, tlast, tuser = chip 0 of a word)
module barker_spreader
    import barker_pkg::*;
#(
    parameter int unsigned PREAMBLE_SYMBOLS = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    barker_spreader_if.slave          s_axis,
    barker_spreader_if.master         m_axis
);

    localparam int unsigned PreW = (PREAMBLE_SYMBOLS > 1) ? $clog2(PREAMBLE_SYMBOLS + 1) : 1;
    localparam logic [PreW-1:0] PreLast =
        PreW'((PREAMBLE_SYMBOLS == 0) ? 0 : PREAMBLE_SYMBOLS - 1);
    localparam logic [3:0] ChipLast = 4'(BARKER_LEN - 1);
    localparam bit NoPreamble = (PREAMBLE_SYMBOLS == 0);

    spreader_state_t state_q, state_d;
    logic [3:0]      chip_cnt_q, chip_cnt_d;
    logic [PreW-1:0] pre_cnt_q, pre_cnt_d;
    logic            sym_bit_q, sym_bit_d;
    logic            frame_last_q, frame_last_d;

    logic m_valid, m_hs, eow, load_pt, s_ready, s_hs, word_bit, chip;

    barker_chip_rom u_rom (
        .chip_idx (chip_cnt_q),
        .sym_bit  (word_bit),
        .chip     (chip)
    );

    always_comb begin
        m_valid  = (state_q == StPreamble) || (state_q == StData);
        m_hs     = m_valid && m_axis.tready;
        eow      = m_hs && (chip_cnt_q == ChipLast);
        word_bit = (state_q == StPreamble) ? 1'b1 : sym_bit_q;
        // Word boundary where the next payload beat may be taken without a gap.
        load_pt  = eow && (((state_q == StPreamble) && (pre_cnt_q == PreLast)) ||
                           ((state_q == StData) && !frame_last_q));
        s_ready  = load_pt || (state_q == StLoad) || ((state_q == StIdle) && NoPreamble);
        s_hs     = s_axis.tvalid && s_ready;
    end

    always_comb begin
        state_d      = state_q;
        chip_cnt_d   = chip_cnt_q;
        pre_cnt_d    = pre_cnt_q;
        sym_bit_d    = sym_bit_q;
        frame_last_d = frame_last_q;

        if (m_hs) begin
            chip_cnt_d = eow ? 4'd0 : chip_cnt_q + 4'd1;
        end

        if (s_hs) begin
            sym_bit_d    = s_axis.tdata;
            frame_last_d = s_axis.tlast;
        end

        case (state_q)
            StIdle: begin
                if (s_hs) begin
                    state_d = StData;
                end else if (!NoPreamble && s_axis.tvalid) begin
                    // Beat is left pending; it is taken at the end of the preamble.
                    state_d   = StPreamble;
                    pre_cnt_d = '0;
                end
            end
            StPreamble: begin
                if (eow) begin
                    pre_cnt_d = pre_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (eow && frame_last_q) begin
                    state_d = StIdle;
                end
            end
            StLoad: begin
                if (s_hs) begin
                    state_d = StData;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load_pt) begin
            state_d = s_axis.tvalid ? StData : StLoad;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            chip_cnt_q   <= '0;
            pre_cnt_q    <= '0;
            sym_bit_q    <= 1'b0;
            frame_last_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            chip_cnt_q   <= chip_cnt_d;
            pre_cnt_q    <= pre_cnt_d;
            sym_bit_q    <= sym_bit_d;
            frame_last_q <= frame_last_d;
        end
    end

    always_comb begin
        m_axis.tvalid = m_valid;
        m_axis.tdata  = m_valid && chip;
        m_axis.tuser  = m_valid && (chip_cnt_q == 4'd0);
        m_axis.tlast  = (state_q == StData) && (chip_cnt_q == ChipLast) && frame_last_q;
        s_axis.tready = s_ready;
    end

endmodule

// File: tb/tb_barker_spreader.sv
// Directed bench for barker_spreader: one instance with a 1-word preamble and
// one without; a select line routes stimulus to one instance at a time.
module tb_barker_spreader;

    logic clk = 1'b0;
    logic rst_n;
    logic sel;
    logic s_tvalid, s_tdata, s_tlast, m_tready;

    always #5 clk = ~clk;

    barker_spreader_if s_if1 ();
    barker_spreader_if m_if1 ();
    barker_spreader_if s_if0 ();
    barker_spreader_if m_if0 ();

    assign s_if1.tvalid = !sel && s_tvalid;
    assign s_if1.tdata  = s_tdata;
    assign s_if1.tlast  = s_tlast;
    assign s_if1.tuser  = 1'b0;
    assign m_if1.tready = m_tready;
    assign s_if0.tvalid = sel && s_tvalid;
    assign s_if0.tdata  = s_tdata;
    assign s_if0.tlast  = s_tlast;
    assign s_if0.tuser  = 1'b0;
    assign m_if0.tready = m_tready;

    barker_spreader #(.PREAMBLE_SYMBOLS(1)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .s_axis  (s_if1),
        .m_axis  (m_if1)
    );

    barker_spreader #(.PREAMBLE_SYMBOLS(0)) dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .s_axis  (s_if0),
        .m_axis  (m_if0)
    );

    logic o_tvalid, o_tdata, o_tuser, o_tlast, o_sready;
    assign o_tvalid = sel ? m_if0.tvalid : m_if1.tvalid;
    assign o_tdata  = sel ? m_if0.tdata  : m_if1.tdata;
    assign o_tuser  = sel ? m_if0.tuser  : m_if1.tuser;
    assign o_tlast  = sel ? m_if0.tlast  : m_if1.tlast;
    assign o_sready = sel ? s_if0.tready : s_if1.tready;

    logic [0:12] code_seq = 13'b1111100110101;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic got_chip[$];
    logic got_user[$];
    logic got_last[$];
    int   sr_pos[$];
    int   bubbles;
    int   first_lat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one frame from IDLE and records every accepted chip.
    task automatic run_frame(input int nbits, input logic [31:0] bits, input bit rnd,
                             input int gap_idx, input int gap_len);
        int   idx = 0;
        int   cyc = 0;
        int   first_cyc = -1;
        int   t_sv = -1;
        int   gcnt = 0;
        bit   gapping = 0;
        bit   done = 0;
        bit   sv;
        logic pv_stall = 0;
        logic [3:0] pv_vec = 4'h0;
        got_chip.delete();
        got_user.delete();
        got_last.delete();
        sr_pos.delete();
        bubbles = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            m_tready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            if (pv_stall) check("stall_hold", {o_tvalid, o_tdata, o_tuser, o_tlast}, pv_vec);
            if (o_tvalid && !m_tready) check("stall_sready", o_sready, 0);
            if (o_tvalid) begin
                if (first_cyc < 0) first_cyc = cyc;
            end else if (first_cyc >= 0) begin
                bubbles++;
            end
            if (o_sready && first_cyc >= 0) sr_pos.push_back(cyc - first_cyc);
            if (o_tvalid && m_tready) begin
                got_chip.push_back(o_tdata);
                got_user.push_back(o_tuser);
                got_last.push_back(o_tlast);
                if (o_tlast) done = 1;
            end
            if (idx == gap_idx && gcnt < gap_len) begin
                if (o_sready) gapping = 1;
                if (gapping) gcnt++;
                sv = 0;
            end else begin
                sv = (idx < nbits);
            end
            if (sv && t_sv < 0) t_sv = cyc;
            s_tvalid = sv;
            s_tdata  = bits[idx];
            s_tlast  = (idx == nbits - 1);
            if (sv && o_sready) idx++;
            pv_stall = o_tvalid && !m_tready;
            pv_vec   = {o_tvalid, o_tdata, o_tuser, o_tlast};
            cyc++;
        end
        s_tvalid  = 0;
        s_tlast   = 0;
        m_tready  = 1;
        first_lat = first_cyc - t_sv;
        if (!done) check("frame_timeout", 0, 1);
    endtask

    task automatic check_stream(input string tag, input int p, input int nbits,
                                input logic [31:0] bits);
        int n;
        n = 13 * (p + nbits);
        check({tag, "_len"}, got_chip.size(), n);
        for (int i = 0; i < n && i < got_chip.size(); i++) begin
            int   w;
            int   c;
            logic b;
            logic e;
            w = i / 13;
            c = i % 13;
            b = (w < p) ? 1'b1 : bits[w - p];
            e = b ? code_seq[c] : ~code_seq[c];
            check({tag, "_chip"}, {got_chip[i], got_user[i], got_last[i]},
                  {e, (c == 0), (i == n - 1)});
        end
    endtask

    task automatic after_frame(input string tag, input logic exp_sready);
        @(negedge clk);
        #1;
        check({tag, "_idle_tvalid"}, o_tvalid, 0);
        check({tag, "_idle_sready"}, o_sready, exp_sready);
    endtask

    initial begin
        int  chips;
        bit  hit;
        sel      = 0;
        s_tvalid = 0;
        s_tdata  = 0;
        s_tlast  = 0;
        m_tready = 1;
        rst_n    = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_p1_outs", {m_if1.tvalid, m_if1.tdata, m_if1.tuser, m_if1.tlast, s_if1.tready},
              0);
        check("rst_p0_outs", {m_if0.tvalid, m_if0.tdata, m_if0.tuser, m_if0.tlast}, 0);
        @(negedge clk);
        rst_n = 1;

        // P=1, bits 1 then 0 (last)
        run_frame(2, 32'b01, 0, -1, 0);
        check("t1_latency", first_lat, 1);
        check_stream("t1", 1, 2, 32'b01);
        check("t1_bubbles", bubbles, 0);
        check("t1_sready_n", sr_pos.size(), 2);
        if (sr_pos.size() == 2) begin
            check("t1_sready_a", sr_pos[0], 12);
            check("t1_sready_b", sr_pos[1], 25);
        end
        after_frame("t1", 1'b0);

        // P=0, single bit 0
        sel = 1;
        run_frame(1, 32'b0, 0, -1, 0);
        check("t2_latency", first_lat, 1);
        check_stream("t2", 0, 1, 32'b0);
        after_frame("t2", 1'b1);
        sel = 0;

        // Random downstream ready, 8-bit frame
        run_frame(8, 32'hB2, 1, -1, 0);
        check_stream("t3", 1, 8, 32'hB2);
        check("t3_bubbles", bubbles, 0);
        after_frame("t3", 1'b0);

        // Source underrun of 5 cycles before the third bit
        run_frame(4, 32'h6, 0, 2, 5);
        check_stream("t4", 1, 4, 32'h6);
        check("t4_bubbles", bubbles, 5);
        after_frame("t4", 1'b0);

        // Reset pulsed at chip 6 of the first payload word
        chips    = 0;
        hit      = 0;
        s_tvalid = 1;
        s_tdata  = 1;
        s_tlast  = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk);
            #1;
            if (o_tvalid) begin
                if (chips == 19) hit = 1;
                else chips++;
            end
        end
        check("t5_reached", hit, 1);
        check("t5_pre_user", o_tuser, 0);
        rst_n    = 0;
        s_tvalid = 0;
        #1;
        check("t5_rst_async", {o_tvalid, o_tdata, o_tuser, o_tlast, o_sready}, 0);
        @(negedge clk);
        rst_n = 1;
        run_frame(3, 32'h5, 0, -1, 0);
        check_stream("t5", 1, 3, 32'h5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
